// File: rtl/avalon_pkg.sv
// avalon_pkg: shared state encoding, LFSR seed and reset vector for the Avalon bus responder and CPU bench
package avalon_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  localparam logic [7:0]  LFSR_SEED    = 8'hA5;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction
endpackage

// File: rtl/avalon_wait_gen.sv
// avalon_wait_gen: wait-state down-counter with optional LFSR-derived extra cycles
//   clk, reset (async, active-low); start: load counter for a newly accepted request;
//   extra_en: add lfsr[1:0] cycles and step the LFSR per start; done: transfer may enter ACK
module avalon_wait_gen import avalon_pkg::*; #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic extra_en,
  output logic done
);
  logic [7:0] r_lfsr;
  logic [4:0] r_cnt;
  logic [4:0] w_load;
  always_comb w_load = 5'(WAIT_CYCLES) + (extra_en ? {3'b000, r_lfsr[1:0]} : 5'd0);
  // On the accepting cycle the decision comes from the value being loaded,
  // afterwards from the running count reaching 1.
  always_comb done = start ? (w_load == 5'd0) : (r_cnt == 5'd1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_lfsr <= LFSR_SEED;
      r_cnt  <= '0;
    end else if (start) begin
      r_cnt <= w_load;
      if (extra_en) r_lfsr <= lfsr_next(r_lfsr);
    end else if (r_cnt != 5'd0) begin
      r_cnt <= r_cnt - 5'd1;
    end
endmodule

// File: rtl/avalon_mem_responder.sv
// avalon_mem_responder: Avalon-MM responder memory with wait states and sticky bus-violation flag
//   clk; reset (async, active-low); address/read/write/writedata/byteenable: master request;
//   waitrequest: hold request; readdata: valid in the ACK cycle of a read; err: sticky violation
module avalon_mem_responder import avalon_pkg::*; #(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          WAIT_CYCLES = 1,
  parameter bit          RAND_WAIT   = 1'b0,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err
);
  localparam int AW = $clog2(MEM_WORDS);
  state_t r_state, w_next;
  logic [31:0] r_mem [MEM_WORDS];
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic [AW-1:0] r_idx;
  logic r_rd, r_wr, r_bad;
  logic w_req, w_start, w_done, w_changed, w_ibad, w_rdop, w_rbad;
  logic [31:0] w_ioff;
  logic [AW-1:0] w_ridx;
  logic w_unused_init;
  // Memory contents start undefined; the image name is kept for interface compatibility.
  assign w_unused_init = (INIT_FILE != "");
  assign w_req  = read | write;
  assign w_ioff = address - BASE_ADDR;
  // Unsigned offset compare covers both ends of the window (below base wraps high).
  assign w_ibad = (read & write) | (|address[1:0]) | (w_ioff >= 32'(4 * MEM_WORDS));
  assign w_changed = ({read, write} != {r_rd, r_wr}) | (address != r_addr) |
                     (writedata != r_wdata) | (byteenable != r_be);
  // Zero-wait transfers enter ACK straight from IDLE, so the read path uses the live request there.
  assign w_rdop = (r_state == IDLE) ? read : r_rd;
  assign w_rbad = (r_state == IDLE) ? w_ibad : r_bad;
  assign w_ridx = (r_state == IDLE) ? w_ioff[AW+1:2] : r_idx;
  avalon_wait_gen #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .start    (w_start),
    .extra_en (RAND_WAIT),
    .done     (w_done)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == IDLE) ? (w_req ? (w_done ? ACK : WAIT) : IDLE) :
             (r_state == WAIT) ? (w_changed ? IDLE : (w_done ? ACK : WAIT)) : IDLE;
  always_comb begin
    w_start     = (r_state == IDLE) & w_req;
    waitrequest = ~reset | ((r_state != ACK) & w_req);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_idx    <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_bad    <= 1'b0;
      readdata <= '0;
      err      <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr  <= address;
        r_wdata <= writedata;
        r_be    <= byteenable;
        r_idx   <= w_ioff[AW+1:2];
        r_rd    <= read;
        r_wr    <= write;
        r_bad   <= w_ibad;
      end
      if ((w_start & w_ibad) | ((r_state == WAIT) & w_changed)) err <= 1'b1;
      if ((w_next == ACK) & (w_rbad | w_rdop)) readdata <= w_rbad ? 32'd0 : r_mem[w_ridx];
    end
  // Commit on the edge that ends ACK; reset forces IDLE so an abandoned transfer never writes.
  always_ff @(posedge clk)
    if ((r_state == ACK) & r_wr & ~r_bad)
      for (int i = 0; i < 4; i++)
        if (r_be[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
endmodule

// File: tb/tb_avalon_mem_responder.sv
// tb_avalon_mem_responder: directed table, corner sequences and randomized model check of avalon_mem_responder
module tb_avalon_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  logic rd [3], wr [3], wreq [3], errs [3];
  logic [31:0] addr [3], wdat [3], rdat [3];
  logic [3:0] be [3];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  avalon_mem_responder #(.WAIT_CYCLES(0), .RAND_WAIT(1'b0)) u_d0 (
    .clk(clk), .reset(rst_n), .address(addr[0]), .read(rd[0]), .write(wr[0]),
    .writedata(wdat[0]), .byteenable(be[0]), .waitrequest(wreq[0]), .readdata(rdat[0]), .err(errs[0]));
  avalon_mem_responder #(.WAIT_CYCLES(3), .RAND_WAIT(1'b0)) u_d1 (
    .clk(clk), .reset(rst_n), .address(addr[1]), .read(rd[1]), .write(wr[1]),
    .writedata(wdat[1]), .byteenable(be[1]), .waitrequest(wreq[1]), .readdata(rdat[1]), .err(errs[1]));
  avalon_mem_responder #(.WAIT_CYCLES(1), .RAND_WAIT(1'b1)) u_d2 (
    .clk(clk), .reset(rst_n), .address(addr[2]), .read(rd[2]), .write(wr[2]),
    .writedata(wdat[2]), .byteenable(be[2]), .waitrequest(wreq[2]), .readdata(rdat[2]), .err(errs[2]));
  typedef struct {
    int d; logic r; logic w; logic [31:0] a; logic [31:0] wd; logic [3:0] be;
    int ew; logic cr; logic [31:0] erd; logic ee;
  } vec_t;
  vec_t tv [$];
  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s #%0d: got %h expected %h", nm, idx, got, exp);
    end
  endtask
  // Called just after a rising edge; returns just after the edge that ends ACK.
  task automatic xfer(input int d, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] b,
                      output int n, output logic [31:0] q, output logic e);
    rd[d] = r; wr[d] = w; addr[d] = a; wdat[d] = wd; be[d] = b;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!wreq[d]) break;
      n++;
    end
    if (n >= 64) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout dut%0d addr %h: waitrequest stuck high, required low", d, a);
    end
    q = rdat[d];
    e = errs[d];
    @(posedge clk); #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask
  initial begin
    int n;
    logic [31:0] q, exp_w;
    logic e;
    logic [7:0] m_lfsr;
    logic [31:0] m_mem [16];
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdat[i] = '0; be[i] = '0;
    end
    tv.push_back(vec_t'{0, 1'b0, 1'b1, 32'hBFC00000, 32'h2402000A, 4'hF, 1, 1'b0, 32'h0, 1'b0});
    tv.push_back(vec_t'{0, 1'b1, 1'b0, 32'hBFC00000, 32'h0,        4'hF, 1, 1'b1, 32'h2402000A, 1'b0});
    tv.push_back(vec_t'{0, 1'b0, 1'b1, 32'hBFC00FFC, 32'hCAFEF00D, 4'hF, 1, 1'b0, 32'h0, 1'b0});
    tv.push_back(vec_t'{0, 1'b1, 1'b0, 32'hBFC00FFC, 32'h0,        4'h0, 1, 1'b1, 32'hCAFEF00D, 1'b0});
    tv.push_back(vec_t'{1, 1'b0, 1'b1, 32'hBFC00010, 32'h11223344, 4'hF, 4, 1'b0, 32'h0, 1'b0});
    tv.push_back(vec_t'{1, 1'b1, 1'b0, 32'hBFC00010, 32'h0,        4'hF, 4, 1'b1, 32'h11223344, 1'b0});
    tv.push_back(vec_t'{1, 1'b0, 1'b1, 32'hBFC00010, 32'hAABBCCDD, 4'h5, 4, 1'b0, 32'h0, 1'b0});
    tv.push_back(vec_t'{1, 1'b1, 1'b0, 32'hBFC00010, 32'h0,        4'hF, 4, 1'b1, 32'h11BB33DD, 1'b0});
    tv.push_back(vec_t'{1, 1'b0, 1'b1, 32'hBFC00010, 32'hFFFFFFFF, 4'h0, 4, 1'b0, 32'h0, 1'b0});
    tv.push_back(vec_t'{1, 1'b1, 1'b0, 32'hBFC00010, 32'h0,        4'hF, 4, 1'b1, 32'h11BB33DD, 1'b0});
    tv.push_back(vec_t'{1, 1'b0, 1'b1, 32'hBFC00010, 32'h99887766, 4'hA, 4, 1'b0, 32'h0, 1'b0});
    tv.push_back(vec_t'{1, 1'b1, 1'b0, 32'hBFC00010, 32'h0,        4'hF, 4, 1'b1, 32'h99BB77DD, 1'b0});
    tv.push_back(vec_t'{0, 1'b1, 1'b1, 32'hBFC00000, 32'hDEADBEEF, 4'hF, 1, 1'b1, 32'h0, 1'b1});
    tv.push_back(vec_t'{0, 1'b1, 1'b0, 32'hBFC00000, 32'h0,        4'hF, 1, 1'b1, 32'h2402000A, 1'b1});
    tv.push_back(vec_t'{0, 1'b1, 1'b0, 32'hBFC00002, 32'h0,        4'hF, 1, 1'b1, 32'h0, 1'b1});
    tv.push_back(vec_t'{0, 1'b1, 1'b0, 32'hBFC00FFC, 32'h0,        4'hF, 1, 1'b1, 32'hCAFEF00D, 1'b1});
    tv.push_back(vec_t'{0, 1'b1, 1'b0, 32'h00000000, 32'h0,        4'hF, 1, 1'b1, 32'h0, 1'b1});
    tv.push_back(vec_t'{0, 1'b0, 1'b1, 32'hBFC00002, 32'hFFFFFFFF, 4'hF, 1, 1'b0, 32'h0, 1'b1});
    tv.push_back(vec_t'{0, 1'b0, 1'b1, 32'hBFC01000, 32'hFFFFFFFF, 4'hF, 1, 1'b0, 32'h0, 1'b1});
    tv.push_back(vec_t'{0, 1'b0, 1'b1, 32'h00000000, 32'hFFFFFFFF, 4'hF, 1, 1'b0, 32'h0, 1'b1});
    tv.push_back(vec_t'{0, 1'b1, 1'b0, 32'hBFC00000, 32'h0,        4'hF, 1, 1'b1, 32'h2402000A, 1'b1});
    tv.push_back(vec_t'{0, 1'b1, 1'b0, 32'hBFC01000, 32'h0,        4'hF, 1, 1'b1, 32'h0, 1'b1});
    tv.push_back(vec_t'{0, 1'b1, 1'b0, 32'hBFC00FFC, 32'h0,        4'hF, 1, 1'b1, 32'hCAFEF00D, 1'b1});
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_waitreq", 0, 32'(wreq[0]), 32'd1);
    chk("reset_readdata", 0, rdat[0], 32'd0);
    chk("reset_err", 0, 32'(errs[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_req_waitreq", 0, 32'(wreq[0]), 32'd0);
    foreach (tv[i]) begin
      xfer(tv[i].d, tv[i].r, tv[i].w, tv[i].a, tv[i].wd, tv[i].be, n, q, e);
      chk("wait_cycles", i, 32'(n), 32'(tv[i].ew));
      if (tv[i].cr) chk("readdata", i, q, tv[i].erd);
      chk("err", i, 32'(e), 32'(tv[i].ee));
    end
    // master drops read in the middle of the wait phase
    rd[1] = 1'b1; addr[1] = 32'hBFC00010;
    @(negedge clk);
    chk("abort_waitreq_idle", 0, 32'(wreq[1]), 32'd1);
    @(posedge clk); #1;
    rd[1] = 1'b0;
    @(negedge clk);
    chk("abort_waitreq_dropped", 0, 32'(wreq[1]), 32'd0);
    @(posedge clk); #1;
    chk("abort_err", 0, 32'(errs[1]), 32'd1);
    xfer(1, 1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'hF, n, q, e);
    chk("after_abort_wait", 0, 32'(n), 32'd4);
    chk("after_abort_readdata", 0, q, 32'h99BB77DD);
    // reset asserted while a write sits in its wait phase
    wr[1] = 1'b1; addr[1] = 32'hBFC00010; wdat[1] = 32'h55667788; be[1] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_waitreq", 0, 32'(wreq[1]), 32'd1);
    chk("rst_mid_err_cleared", 0, 32'(errs[1]), 32'd0);
    chk("rst_forced_waitreq", 0, 32'(wreq[0]), 32'd1);
    chk("rst_readdata_cleared", 0, rdat[0], 32'd0);
    repeat (2) @(posedge clk);
    #1 wr[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1, 1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'hF, n, q, e);
    chk("rst_word_unchanged", 0, q, 32'h99BB77DD);
    chk("rst_after_wait", 0, 32'(n), 32'd4);
    chk("rst_after_err", 0, 32'(e), 32'd0);
    // randomized traffic on the random-wait responder, model restarts from the seed
    m_lfsr = 8'hA5;
    for (int i = 0; i < 76; i++) begin
      logic r;
      logic [3:0] b;
      logic [31:0] d;
      int w;
      r = (i >= 16) && ($urandom_range(0, 1) == 1);
      w = (i < 16) ? i : int'($urandom_range(0, 15));
      b = (i < 16) ? 4'hF : 4'($urandom);
      d = $urandom;
      xfer(2, r, ~r, 32'hBFC00000 + 32'(4 * w), d, b, n, q, e);
      chk("rand_wait", i, 32'(n), 32'(2 + int'(m_lfsr[1:0])));
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      if (r) chk("rand_readdata", i, q, m_mem[w]);
      else begin
        exp_w = m_mem[w];
        for (int k = 0; k < 4; k++) if (b[k]) exp_w[8*k +: 8] = d[8*k +: 8];
        m_mem[w] = exp_w;
      end
      chk("rand_err", i, 32'(e), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
